pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_hazard_ctrl_md_occupancy.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Forwarding select codes, HI/LO occupancy states and the default mult/div latency.
package pipe_pkg;

    localparam int MD_LATENCY_DEFAULT = 32;
    localparam int WIDTH_DEFAULT      = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Operand source for one Execute operand; the younger (MEM) producer wins.
    function automatic fwd_sel_t fwd_pick(
        input logic [4:0] src,
        input logic       en_m,
        input logic [4:0] dst_m,
        input logic       en_w,
        input logic [4:0] dst_w
    );
        if (en_m && (dst_m != 5'd0) && (dst_m == src))
            return FWD_MEM;
        else if (en_w && (dst_w != 5'd0) && (dst_w == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_occupancy.sv
// HI/LO unit occupancy tracker: IDLE/BUSY FSM plus 8-bit down-counter.
// A start from Execute keeps the unit busy for exactly MD_LATENCY cycles
// after the start cycle; starts while busy are ignored.
module md_occupancy
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic md_start_i,
    output logic md_busy
);

    // Counter holds the number of busy cycles still to come after the current one.
    localparam logic [7:0] LOAD_VAL = 8'(MD_LATENCY - 1);

    md_state_t  r_state;
    logic [7:0] r_cnt;

    // Occupancy FSM and remaining-cycle counter; reset aborts any count in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (md_start_i) begin
                        r_state <= BUSY;
                        r_cnt   <= LOAD_VAL;
                    end
                end
                BUSY: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign md_busy = (r_state == BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use / RAW stalls,
// HI/LO structural stall and taken-branch flush.
// Build option: define PIPE_FORWARDING_EN to enable forwarding; without it the
// forwarding selects stay at the register file and any RAW dependency on an
// EX or MEM producer stalls Decode instead.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int WIDTH      = WIDTH_DEFAULT
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [4:0] rs_addr_id5,
    input  logic [4:0] rt_addr_id5,
    input  logic [4:0] rs_addr_ie5,
    input  logic [4:0] rt_addr_ie5,
    input  logic [4:0] dst_reg_addr_ie5,
    input  logic       enable_wreg_ie,
    input  logic       mem_to_reg_ie,
    input  logic [4:0] dst_reg_addr_om5,
    input  logic       enable_wreg_om,
    input  logic [4:0] dst_reg_addr_ow5,
    input  logic       enable_wreg_ow,
    input  logic       branch_taken_om,
    input  logic       md_start_ie,
    input  logic       md_use_id,
    output logic       stall_f_o,
    output logic       stall_d_o,
    output logic       flush_d_o,
    output logic       flush_e_o,
    output logic [1:0] fwd_a_oe2,
    output logic [1:0] fwd_b_oe2,
    output logic       md_busy_o
);

    logic             w_md_busy;
    logic             w_load_use;
    logic             w_data_stall;
    logic             w_struct_stall;
    logic             w_stall;
    logic [WIDTH-1:0] w_unused_width;

    // Datapath width is carried for package consistency only.
    assign w_unused_width = '0;

    md_occupancy #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_occupancy (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .md_start_i (md_start_ie),
        .md_busy    (w_md_busy)
    );

    assign md_busy_o = w_md_busy;

    // A load in Execute cannot forward in time for a dependent instruction in Decode.
    assign w_load_use = mem_to_reg_ie && (dst_reg_addr_ie5 != 5'd0) &&
                        ((dst_reg_addr_ie5 == rs_addr_id5) ||
                         (dst_reg_addr_ie5 == rt_addr_id5));

`ifdef PIPE_FORWARDING_EN

    logic w_unused_fwd;
    assign w_unused_fwd = enable_wreg_ie;

    // Operand selects for Execute, MEM producer first.
    always_comb begin
        fwd_a_oe2 = fwd_pick(rs_addr_ie5, enable_wreg_om, dst_reg_addr_om5,
                             enable_wreg_ow, dst_reg_addr_ow5);
        fwd_b_oe2 = fwd_pick(rt_addr_ie5, enable_wreg_om, dst_reg_addr_om5,
                             enable_wreg_ow, dst_reg_addr_ow5);
    end

    assign w_data_stall = w_load_use;

`else

    logic w_unused_fwd;
    logic w_raw_rs;
    logic w_raw_rt;

    // EX operand addresses and the WB producer do not matter without forwarding;
    // the register file writes before it reads.
    assign w_unused_fwd = ^{rs_addr_ie5, rt_addr_ie5, dst_reg_addr_ow5, enable_wreg_ow};

    // Any Decode source still in flight in EX or MEM must wait.
    always_comb begin
        fwd_a_oe2 = FWD_RF;
        fwd_b_oe2 = FWD_RF;
        w_raw_rs  = (rs_addr_id5 != 5'd0) &&
                    ((enable_wreg_ie && (dst_reg_addr_ie5 == rs_addr_id5)) ||
                     (enable_wreg_om && (dst_reg_addr_om5 == rs_addr_id5)));
        w_raw_rt  = (rt_addr_id5 != 5'd0) &&
                    ((enable_wreg_ie && (dst_reg_addr_ie5 == rt_addr_id5)) ||
                     (enable_wreg_om && (dst_reg_addr_om5 == rt_addr_id5)));
    end

    assign w_data_stall = w_load_use || w_raw_rs || w_raw_rt;

`endif

    // HI/LO reader or new mult/div must wait while the unit is occupied.
    assign w_struct_stall = w_md_busy && md_use_id;

    // Coincident hazards collapse into a single stall.
    assign w_stall = w_data_stall || w_struct_stall;

    // A taken branch squashes the younger instructions and overrides every stall.
    always_comb begin
        stall_f_o = w_stall && !branch_taken_om;
        stall_d_o = w_stall && !branch_taken_om;
        flush_d_o = branch_taken_om;
        flush_e_o = w_stall || branch_taken_om;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MD_LATENCY = 4).
// Expectations follow whichever forwarding build is compiled.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;

`ifdef PIPE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [4:0] rs_addr_id5, rt_addr_id5, rs_addr_ie5, rt_addr_ie5;
    logic [4:0] dst_reg_addr_ie5, dst_reg_addr_om5, dst_reg_addr_ow5;
    logic       enable_wreg_ie, mem_to_reg_ie, enable_wreg_om, enable_wreg_ow;
    logic       branch_taken_om, md_start_ie, md_use_id;
    logic       stall_f_o, stall_d_o, flush_d_o, flush_e_o, md_busy_o;
    logic [1:0] fwd_a_oe2, fwd_b_oe2;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_hazard_ctrl #(.MD_LATENCY(LAT), .WIDTH(8)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .rs_addr_id5      (rs_addr_id5),
        .rt_addr_id5      (rt_addr_id5),
        .rs_addr_ie5      (rs_addr_ie5),
        .rt_addr_ie5      (rt_addr_ie5),
        .dst_reg_addr_ie5 (dst_reg_addr_ie5),
        .enable_wreg_ie   (enable_wreg_ie),
        .mem_to_reg_ie    (mem_to_reg_ie),
        .dst_reg_addr_om5 (dst_reg_addr_om5),
        .enable_wreg_om   (enable_wreg_om),
        .dst_reg_addr_ow5 (dst_reg_addr_ow5),
        .enable_wreg_ow   (enable_wreg_ow),
        .branch_taken_om  (branch_taken_om),
        .md_start_ie      (md_start_ie),
        .md_use_id        (md_use_id),
        .stall_f_o        (stall_f_o),
        .stall_d_o        (stall_d_o),
        .flush_d_o        (flush_d_o),
        .flush_e_o        (flush_e_o),
        .fwd_a_oe2        (fwd_a_oe2),
        .fwd_b_oe2        (fwd_b_oe2),
        .md_busy_o        (md_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Control outputs packed as {stall_f, stall_d, flush_d, flush_e}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {stall_f_o, stall_d_o, flush_d_o, flush_e_o}, exp);
    endtask

    task automatic clr();
        rs_addr_id5 = 0; rt_addr_id5 = 0; rs_addr_ie5 = 0; rt_addr_ie5 = 0;
        dst_reg_addr_ie5 = 0; dst_reg_addr_om5 = 0; dst_reg_addr_ow5 = 0;
        enable_wreg_ie = 0; mem_to_reg_ie = 0; enable_wreg_om = 0; enable_wreg_ow = 0;
        branch_taken_om = 0; md_start_ie = 0; md_use_id = 0;
    endtask

    task automatic set_load_use();
        mem_to_reg_ie = 1; enable_wreg_ie = 1; dst_reg_addr_ie5 = 5'd8; rt_addr_id5 = 5'd8;
    endtask

    // A new mult/div must never issue while the HI/LO unit is busy.
    always @(negedge clk_i) begin
        #3;
        if (!reset_i) assert (!(md_start_ie && md_busy_o))
            else $error("md_start_ie while md_busy_o");
    end

    initial begin
        clr();
        #2;
        chk_ctl("reset_ctl", 4'b0000);
        chk("reset_fwd", {fwd_a_oe2, fwd_b_oe2}, 4'b0000);
        chk("reset_busy", {3'b0, md_busy_o}, 4'b0000);
        @(negedge clk_i); reset_i = 0;

        // Forwarding: MEM and WB both write r5, EX rs=5 -> MEM wins.
        @(negedge clk_i); clr();
        enable_wreg_om = 1; dst_reg_addr_om5 = 5; enable_wreg_ow = 1; dst_reg_addr_ow5 = 5; rs_addr_ie5 = 5;
        #2;
        chk("fwd_mem_prio_a", {2'b0, fwd_a_oe2}, FWD ? 4'd2 : 4'd0);
        chk("fwd_mem_prio_b", {2'b0, fwd_b_oe2}, 4'd0);
        chk_ctl("fwd_mem_ctl", 4'b0000);

        // Only WB matches, both operands.
        @(negedge clk_i); clr();
        enable_wreg_ow = 1; dst_reg_addr_ow5 = 5; rs_addr_ie5 = 5; rt_addr_ie5 = 5;
        dst_reg_addr_om5 = 5;  // MEM address matches but MEM is not writing
        #2;
        chk("fwd_wb", {fwd_a_oe2, fwd_b_oe2}, FWD ? 4'b0101 : 4'b0000);

        // Register 0 is never forwarded.
        @(negedge clk_i); clr();
        enable_wreg_om = 1; enable_wreg_ow = 1; enable_wreg_ie = 1;
        #2;
        chk("fwd_r0", {fwd_a_oe2, fwd_b_oe2}, 4'b0000);

        // Load-use: lw r8 in EX, Decode reads r8.
        @(negedge clk_i); clr(); set_load_use();
        #2; chk_ctl("ld_use_c1", 4'b1101);
        @(negedge clk_i); clr(); rt_addr_id5 = 8; enable_wreg_om = 1; dst_reg_addr_om5 = 8;
        #2; chk_ctl("ld_use_c2", FWD ? 4'b0000 : 4'b1101);
        @(negedge clk_i); clr(); rt_addr_id5 = 8; enable_wreg_ow = 1; dst_reg_addr_ow5 = 8;
        #2; chk_ctl("ld_use_c3", 4'b0000);
        @(negedge clk_i); clr(); mem_to_reg_ie = 1; enable_wreg_ie = 1;
        #2; chk_ctl("ld_use_r0", 4'b0000);

        // Taken branch overrides the load-use stall.
        @(negedge clk_i); clr(); set_load_use(); branch_taken_om = 1;
        #2; chk_ctl("branch_over_ld", 4'b0011);

        // MEM writes r3, Decode reads r3.
        @(negedge clk_i); clr(); enable_wreg_om = 1; dst_reg_addr_om5 = 3; rs_addr_id5 = 3;
        #2;
        chk_ctl("raw_mem_ctl", FWD ? 4'b0000 : 4'b1101);
        chk("raw_mem_fwd", {fwd_a_oe2, fwd_b_oe2}, 4'b0000);

        // Mult/div occupancy: busy for LAT cycles after the start cycle.
        @(negedge clk_i); clr(); md_start_ie = 1;
        #2; chk("md_start_busy", {3'b0, md_busy_o}, 4'b0000);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk_i); clr(); md_use_id = 1;
            if (i == 2) set_load_use();
            if (i == 3) branch_taken_om = 1;
            #2;
            chk($sformatf("md_busy_%0d", i), {3'b0, md_busy_o}, 4'b0001);
            chk_ctl($sformatf("md_ctl_%0d", i), (i == 3) ? 4'b0011 : 4'b1101);
        end
        @(negedge clk_i); clr(); md_use_id = 1;
        #2;
        chk("md_release_busy", {3'b0, md_busy_o}, 4'b0000);
        chk_ctl("md_release_ctl", 4'b0000);

        // Reset in the middle of a busy count.
        @(negedge clk_i); clr(); md_start_ie = 1;
        @(negedge clk_i); clr(); md_use_id = 1;
        #2; chk("rst_busy_c1", {3'b0, md_busy_o}, 4'b0001);
        @(negedge clk_i); clr(); md_use_id = 1;
        #2; chk("rst_busy_c2", {3'b0, md_busy_o}, 4'b0001);
        reset_i = 1;
        #1;
        chk("rst_abort_busy", {3'b0, md_busy_o}, 4'b0000);
        chk_ctl("rst_abort_ctl", 4'b0000);
        @(negedge clk_i); reset_i = 0;
        #2;
        chk("post_rst_busy", {3'b0, md_busy_o}, 4'b0000);
        chk_ctl("post_rst_ctl", 4'b0000);
        @(negedge clk_i);
        #2;
        chk_ctl("post_rst_ctl2", 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
